// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the MIPS HI/LO pair.
// Shift-add multiply and restoring divide run on magnitudes; FIX applies signs.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_raw;
    logic               is_div, neg_lo, neg_hi, zero_div;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    // Even op codes are the signed variants.
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    // The difference is always below the divisor, so the low bits are exact.
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    assign prod = neg_lo ? -acc : acc;
    assign quo  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: state_next = MUL;
                        OP_DIV, OP_DIVU:   state_next = DIV;
                        default:           state_next = IDLE;
                    endcase
                end
            end
            MUL:     if (count == LAST) state_next = FIX;
            DIV:     if (count == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            acc         <= '0;
            opnd        <= '0;
            a_raw       <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            zero_div    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                acc    <= {{WIDTH{1'b0}}, b_mag};
                                opnd   <= a_mag;
                                is_div <= 1'b0;
                                neg_lo <= a_neg ^ b_neg;
                                neg_hi <= 1'b0;
                                count  <= '0;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc      <= {{WIDTH{1'b0}}, a_mag};
                                opnd     <= b_mag;
                                is_div   <= 1'b1;
                                neg_lo   <= a_neg ^ b_neg;
                                neg_hi   <= a_neg;
                                zero_div <= (b == '0);
                                a_raw    <= a;
                                count    <= '0;
                            end
                            OP_MTHI: begin
                                hi   <= a;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= a;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc   <= {mul_sum, acc[WIDTH-1:1]};
                    count <= count + 1'b1;
                end
                DIV: begin
                    acc   <= {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
                    count <= count + 1'b1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        div_by_zero <= zero_div;
                        if (zero_div) begin
                            lo <= '1;
                            hi <= a_raw;
                        end else begin
                            lo <= quo;
                            hi <= rem;
                        end
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed plan cases plus random ops
// compared against a plain 64-bit arithmetic model of HI/LO.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic         m_dz = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of each op, in 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = 64'(sx * sy); {m_hi, m_lo} = p; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = p; end
            3'd2, 3'd3: begin
                if (y == 0) begin
                    m_lo = '1; m_hi = x; m_dz = 1'b1;
                end else begin
                    if (o == 3'd3) begin
                        sx = longint'({32'd0, x});
                        sy = longint'({32'd0, y});
                    end
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = q[W-1:0]; m_hi = r[W-1:0]; m_dz = 1'b0;
                end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit poke);
        logic [W-1:0] hi0, lo0;
        int edges, busy_n;
        bit stable;
        hi0 = hi; lo0 = lo;
        model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
        if (o >= 3'd4) begin
            check({tag, " done"}, 64'(done), 64'(o < 3'd6));
            check({tag, " busy"}, 64'(busy), 64'd0);
            check({tag, " hi"}, 64'(hi), 64'(m_hi));
            check({tag, " lo"}, 64'(lo), 64'(m_lo));
            check({tag, " dz"}, 64'(div_by_zero), 64'(m_dz));
            return;
        end
        edges = 0; busy_n = 0; stable = 1'b1;
        while (!done && edges <= 40) begin
            if (busy) busy_n++;
            if (hi !== hi0 || lo !== lo0) stable = 1'b0;
            if (poke && (edges == 5 || edges == 9)) begin
                start = 1'b1;
                op = (edges == 5) ? 3'd4 : 3'd6;
                a = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            start = 1'b0;
            edges++;
        end
        check({tag, " latency"}, 64'(edges), 64'(W + 1));
        check({tag, " busy cycles"}, 64'(busy_n), 64'(W + 1));
        check({tag, " hold"}, 64'(stable), 64'd1);
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(m_hi));
        check({tag, " lo"}, 64'(lo), 64'(m_lo));
        check({tag, " dz"}, 64'(div_by_zero), 64'(m_dz));
    endtask

    initial begin
        int seen_done;
        logic [2:0]   ro;
        logic [W-1:0] rx, ry;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #3;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset dz", 64'(div_by_zero), 64'd0);
        #9 reset = 1'b0;
        @(posedge clk); #1;

        run_op("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu max hi const", 64'(hi), 64'hFFFF_FFFE);
        check("multu max lo const", 64'(lo), 64'h1);
        run_op("mult -7*3", 3'd0, 32'hFFFF_FFF9, 32'd3, 1'b0);
        run_op("mult minneg^2", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("minneg^2 hi const", 64'(hi), 64'h4000_0000);
        run_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div -7/2 lo const", 64'(lo), 64'hFFFF_FFFD);
        check("div -7/2 hi const", 64'(hi), 64'hFFFF_FFFF);
        run_op("divu 100/7", 3'd3, 32'd100, 32'd7, 1'b0);
        run_op("div overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div overflow lo const", 64'(lo), 64'h8000_0000);
        run_op("divu by zero", 3'd3, 32'h1234, 32'd0, 1'b0);
        check("div0 dz const", 64'(div_by_zero), 64'd1);
        run_op("mult after div0", 3'd0, 32'd11, 32'hFFFF_FFFE, 1'b0);
        check("dz sticky", 64'(div_by_zero), 64'd1);
        run_op("div clears dz", 3'd2, 32'd50, 32'hFFFF_FFFB, 1'b0);
        check("dz cleared", 64'(div_by_zero), 64'd0);
        run_op("div signed by zero", 3'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("mthi", 3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0);
        @(posedge clk); #1;
        check("mthi done one cycle", 64'(done), 64'd0);
        run_op("mtlo", 3'd5, 32'h5A5A_0001, 32'd0, 1'b0);
        run_op("reserved op", 3'd6, 32'h1111_1111, 32'd0, 1'b0);
        run_op("mult poked", 3'd0, 32'h0001_2345, 32'hFFFF_0003, 1'b1);

        // Random ops, including back-to-back issue on the done cycle.
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 9));
            run_op("random", ro, rx, ry, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a divide.
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort done", 64'(done), 64'd0);
        @(negedge clk) reset = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        check("no done after abort", 64'(seen_done), 64'd0);
        run_op("multu 3*5", 3'd1, 32'd3, 32'd5, 1'b0);
        check("multu 3*5 lo const", 64'(lo), 64'd15);
        check("multu 3*5 hi const", 64'(hi), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit providing the MIPS HI/LO register pair. It implements mult, multu, div, divu, mthi and mtlo. The datapath issues an operation with a start pulse, stalls on busy, and reads hi/lo after done. It adds sequential, variable-latency execution beside the single-cycle alu32 path.

Parameters:
WIDTH, 32, operand width and width of each of hi and lo; legal values are even and >= 4.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
start  in  1  issue request, sampled on rising clk.
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
a  in  WIDTH  rs operand: multiplicand, dividend, or mthi/mtlo source.
b  in  WIDTH  rt operand: multiplier or divisor.
busy  out  1  iterative operation in progress.
done  out  1  one-cycle pulse: result is valid on hi/lo.
div_by_zero  out  1  sticky for the last completed DIV/DIVU; high when b was 0.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset is asynchronous and aborts any operation in flight.
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
- States: IDLE, MUL, DIV, FIX.
  - Transitions occur on rising clk only.
  - busy=1 exactly in MUL, DIV and FIX.
- Issue: start=1 in IDLE at edge N captures a, b and op. Operands may change after edge N.
- start is ignored while busy=1. Reserved ops are ignored: no state change and no done.
- MULT/MULTU:
  - IDLE→MUL at edge N.
  - Radix-2 shift-add, one bit per cycle, WIDTH iterations on edges N+1..N+WIDTH.
  - MUL→FIX at edge N+WIDTH.
- DIV/DIVU:
  - IDLE→DIV at edge N.
  - Restoring divide, one quotient bit per cycle, WIDTH iterations.
  - DIV→FIX at edge N+WIDTH.
- Signed operations work on magnitudes. FIX applies sign correction and writes hi/lo at edge N+WIDTH+1, then returns to IDLE.
- Timing after that edge: done=1 for exactly one cycle, busy=0. Total latency is WIDTH+1 edges after the issue edge.
- A new start is accepted on the same edge that done is high.
- Product: the full 2*WIDTH-bit product, with hi = upper half and lo = lower half.
- Quotient/remainder:
  - lo = quotient, truncated toward zero.
  - hi = remainder, which takes the sign of the dividend.
- Divide by zero (b=0):
  - Same latency as a normal divide.
  - lo = all ones, hi = a.
  - div_by_zero=1.
- Signed overflow (DIV with a = most-negative value, b = -1): lo = most-negative value, hi = 0, div_by_zero=0.
- div_by_zero is updated only when a DIV/DIVU completes. It is unchanged by MULT and MTHI/MTLO.
- MTHI/MTLO:
  - Single cycle; busy is never asserted.
  - At edge N, hi (or lo) <= a, and the other register is unchanged.
  - done=1 during the cycle after edge N.
- hi/lo are held constant while busy=1. They change only at the FIX edge, the MTHI/MTLO edge, or on reset.
- The datapath must stall while busy=1 before reading hi/lo. The unit does not reject early reads.

Test Plan:
1. Unsigned multiply at WIDTH=32.
   - Stimulus: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF.
   - Response: done pulses exactly 33 edges after issue; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
2. Signed multiply.
   - Stimulus: MULT a=-7 (0xFFFFFFF9), b=3.
   - Response: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
   - Stimulus: MULT a=0x80000000, b=0x80000000.
   - Response: hi=0x40000000, lo=0.
3. Signed divide.
   - Stimulus: DIV a=-7, b=2.
   - Response: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
   - Stimulus: DIVU a=100, b=7.
   - Response: lo=14, hi=2.
   - Stimulus: DIV a=0x80000000, b=-1.
   - Response: lo=0x80000000, hi=0.
4. Divide by zero.
   - Stimulus: DIVU a=0x1234, b=0.
   - Response: after 33 edges lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1.
   - Stimulus: subsequent MULT.
   - Response: div_by_zero stays 1.
   - Stimulus: next DIV with b≠0.
   - Response: div_by_zero clears.
5. Move operations and ignored starts.
   - Stimulus: MTHI a=0xA5A5A5A5.
   - Response: hi updates next edge, done pulses, busy stays 0, lo unchanged.
   - Stimulus: start pulsed mid-MULT, and op=110.
   - Response: both ignored; hi/lo stable until FIX.
6. Reset mid-operation.
   - Stimulus: assert reset asynchronously 10 cycles into a DIV.
   - Response: immediately busy=0, hi=lo=0, no done.
   - Stimulus: deassert reset, then issue MULTU 3×5.
   - Response: lo=15, hi=0 after 33 edges.
